sprite_logo_animator: RTL and testbench

- Parametrised title-screen sprite renderer; next generation of the fixed-size logo and "press start" drawers.
- Sprite bitmap size, screen position and integer scale (1x/2x/4x...) are parameters.
- Reads an external synchronous bitmap ROM through a one-stage pipeline, and adds per-frame animation: blink, scroll-in, or scroll-then-blink.
- Sits between the VGA DrawX/DrawY counters and the colour mapper; one instance per title-screen sprite.

---
 rtl/sprite_logo_animator.sv | 128 ++++++++++++
 tb/tb_sprite_logo_animator.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_logo_animator.sv
// Title-screen sprite renderer: maps DrawX/DrawY onto a bitmap ROM row/column,
// optionally scaled, with per-frame blink, scroll-in, or scroll-then-blink animation.
module sprite_logo_animator #(
    parameter int W            = 96,
    parameter int H            = 16,
    parameter int ADDR_W       = 4,
    parameter int X0           = 272,
    parameter int Y0           = 232,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30,
    parameter int SCROLL_START = 248,
    parameter int SCROLL_STEP  = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [1:0]        mode,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [W-1:0]      rom_data,
    output logic              is_sprite,
    output logic              scroll_done
);
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Extra headroom bits keep every bound comparison free of wrap at column/row 1023
    localparam logic [12:0]      X_LO     = 13'(X0);
    localparam logic [12:0]      X_HI     = 13'(X0 + (W << SCALE_LOG2) - 1);
    localparam logic [12:0]      Y_REST   = 13'(Y0);
    localparam logic [12:0]      SH       = 13'(H << SCALE_LOG2);
    localparam logic [9:0]       OFF_INIT = 10'(SCROLL_START);
    localparam logic [9:0]       OFF_STEP = 10'(SCROLL_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [COL_W-1:0] COL_MSB  = COL_W'(W - 1);

    logic             frame_q_r;
    logic             in_box_q_r;
    logic [COL_W-1:0] col_q_r;
    logic [9:0]       offset_r;
    logic [CNT_W-1:0] blink_cnt_r;
    logic             visible_r;

    logic [12:0]      px_s, py_s, ytop_s, dx_s, dy_s;
    logic             in_box_s;
    logic [COL_W-1:0] col_s;
    logic [COL_W-1:0] bit_idx_s;
    logic             tick_s, blink_en_s, hold_clear_s, show_s;

    // Screen-to-sprite mapping: box test, ROM row address and bitmap column
    always_comb begin
        px_s     = {3'b000, DrawX};
        py_s     = {3'b000, DrawY};
        ytop_s   = Y_REST + (mode[1] ? {3'b000, offset_r} : 13'd0);
        dx_s     = px_s - X_LO;
        dy_s     = py_s - ytop_s;
        in_box_s = (px_s >= X_LO) && (px_s <= X_HI) &&
                   (py_s >= ytop_s) && (py_s <= ytop_s + SH - 13'd1);
        if (in_box_s) begin
            col_s    = COL_W'(dx_s >> SCALE_LOG2);
            rom_addr = ADDR_W'(dy_s >> SCALE_LOG2);
        end else begin
            col_s    = '0;
            rom_addr = '0;
        end
    end

    // Animation control: frame tick detection and blink gating
    always_comb begin
        tick_s       = frame_clk & ~frame_q_r;
        bit_idx_s    = COL_MSB - col_q_r;
        blink_en_s   = mode[0] & (~mode[1] | scroll_done);
        hold_clear_s = mode[0] & mode[1] & ~scroll_done;
        if (blink_en_s) begin
            show_s = visible_r;
        end else begin
            show_s = 1'b1;
        end
    end

    // Pixel pipeline aligned with the one-cycle ROM read, plus registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_q_r   <= 1'b0;
            in_box_q_r  <= 1'b0;
            col_q_r     <= '0;
            is_sprite   <= 1'b0;
            scroll_done <= 1'b0;
        end else begin
            frame_q_r   <= frame_clk;
            in_box_q_r  <= in_box_s;
            col_q_r     <= col_s;
            is_sprite   <= in_box_q_r & rom_data[bit_idx_s] & show_s;
            scroll_done <= (offset_r == 10'd0);
        end
    end

    // Scroll offset and blink phase; restart outranks a coincident frame tick
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            offset_r    <= OFF_INIT;
            blink_cnt_r <= '0;
            visible_r   <= 1'b1;
        end else if (restart) begin
            offset_r    <= OFF_INIT;
            blink_cnt_r <= '0;
            visible_r   <= 1'b1;
        end else begin
            if (tick_s && mode[1]) begin
                offset_r <= (offset_r > OFF_STEP) ? (offset_r - OFF_STEP) : 10'd0;
            end
            // Scroll-then-blink keeps the blink phase parked until the sprite has landed
            if (hold_clear_s) begin
                blink_cnt_r <= '0;
                visible_r   <= 1'b1;
            end else if (tick_s && blink_en_s) begin
                if (blink_cnt_r == CNT_LAST) begin
                    blink_cnt_r <= '0;
                    visible_r   <= ~visible_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_logo_animator.sv
// Self-checking bench: two sprite instances (default 1x, and a 2x with short blink/scroll)
// driven with shared stimulus and compared against an arithmetic model of the sprite rules.
module tb_sprite_logo_animator;
    localparam int W = 96;
    localparam int H = 16;
    localparam int AX0 = 272, AY0 = 232, AS = 0, ABF = 30, AST = 248, ASP = 2;
    localparam int BX0 = 100, BY0 = 50,  BS = 1, BBF = 2,  BST = 6,   BSP = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic        restart = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  rom_addr_a, rom_addr_b;
    logic [95:0] rom_data_a = 96'd0;
    logic [95:0] rom_data_b = 96'd0;
    logic        is_sprite_a, is_sprite_b, scroll_done_a, scroll_done_b;

    logic [95:0] rom_m [2][16];
    int          off_m [2];
    int          bt_m  [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    sprite_logo_animator #(.W(W), .H(H), .ADDR_W(4), .X0(AX0), .Y0(AY0), .SCALE_LOG2(AS),
        .BLINK_FRAMES(ABF), .SCROLL_START(AST), .SCROLL_STEP(ASP)) dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .mode(mode), .restart(restart), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .is_sprite(is_sprite_a), .scroll_done(scroll_done_a));

    sprite_logo_animator #(.W(W), .H(H), .ADDR_W(4), .X0(BX0), .Y0(BY0), .SCALE_LOG2(BS),
        .BLINK_FRAMES(BBF), .SCROLL_START(BST), .SCROLL_STEP(BSP)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .mode(mode), .restart(restart), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .is_sprite(is_sprite_b), .scroll_done(scroll_done_b));

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        rom_data_a <= rom_m[0][rom_addr_a];
        rom_data_b <= rom_m[1][rom_addr_b];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int p_x0(int d);  return (d == 0) ? AX0 : BX0; endfunction
    function automatic int p_y0(int d);  return (d == 0) ? AY0 : BY0; endfunction
    function automatic int p_sc(int d);  return (d == 0) ? AS  : BS;  endfunction
    function automatic int p_bf(int d);  return (d == 0) ? ABF : BBF; endfunction
    function automatic int p_st(int d);  return (d == 0) ? AST : BST; endfunction
    function automatic int p_sp(int d);  return (d == 0) ? ASP : BSP; endfunction

    // Expected lit state of screen pixel (x,y) for instance d under the current model state
    function automatic logic model_px(int d, int x, int y);
        int   ytop, sw, sh, row, col;
        logic show;
        ytop = p_y0(d) + (mode[1] ? off_m[d] : 0);
        sw = W << p_sc(d);
        sh = H << p_sc(d);
        if (x < p_x0(d) || x >= p_x0(d) + sw || y < ytop || y >= ytop + sh) return 1'b0;
        row = (y - ytop) >> p_sc(d);
        col = (x - p_x0(d)) >> p_sc(d);
        if (mode == 2'b01 || (mode == 2'b11 && off_m[d] == 0))
            show = ((bt_m[d] / p_bf(d)) % 2) == 0;
        else
            show = 1'b1;
        return rom_m[d][row][W-1-col] & show;
    endfunction

    task automatic model_restart();
        for (int d = 0; d < 2; d++) begin
            off_m[d] = p_st(d);
            bt_m[d]  = 0;
        end
    endtask

    task automatic drive_sample(input int x, input int y, output logic sa, output logic sb);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(negedge Clk);
        @(negedge Clk);
        sa = is_sprite_a;
        sb = is_sprite_b;
    endtask

    task automatic frame_tick();
        bit done_before;
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        for (int d = 0; d < 2; d++) begin
            done_before = (off_m[d] == 0);
            if (mode == 2'b01) bt_m[d]++;
            if (mode == 2'b11) bt_m[d] = done_before ? bt_m[d] + 1 : 0;
            if (mode[1]) off_m[d] = (off_m[d] > p_sp(d)) ? off_m[d] - p_sp(d) : 0;
        end
        @(negedge Clk);
    endtask

    task automatic do_restart();
        @(negedge Clk);
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        model_restart();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (is_sprite_a !== 1'b0) begin n_bad++; $display("FAIL reset_is_sprite_a: got %b want 0", is_sprite_a); end
        n_cmp++; if (is_sprite_b !== 1'b0) begin n_bad++; $display("FAIL reset_is_sprite_b: got %b want 0", is_sprite_b); end
        n_cmp++; if (scroll_done_a !== 1'b0) begin n_bad++; $display("FAIL reset_scroll_done_a: got %b want 0", scroll_done_a); end
        n_cmp++; if (scroll_done_b !== 1'b0) begin n_bad++; $display("FAIL reset_scroll_done_b: got %b want 0", scroll_done_b); end
        n_cmp++; if (rom_addr_a !== 4'd0) begin n_bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr_a); end
    endtask

    task automatic test_static_bounds();
        int   xs [5] = '{272, 367, 368, 271, 272};
        int   ys [5] = '{232, 232, 232, 232, 248};
        logic ex [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic sa, sb;
        mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            drive_sample(xs[i], ys[i], sa, sb);
            n_cmp++; if (sa !== ex[i]) begin n_bad++; $display("FAIL static_bound_%0d (%0d,%0d): got %b want %b", i, xs[i], ys[i], sa, ex[i]); end
        end
    endtask

    task automatic test_scale();
        logic sa, sb;
        int   xs [3] = '{100, 101, 102};
        logic ex [3] = '{1'b1, 1'b1, 1'b0};
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            drive_sample(xs[i], 50, sb, sa);
            sb = is_sprite_b;
            n_cmp++; if (sb !== ex[i]) begin n_bad++; $display("FAIL scale_x%0d: got %b want %b", xs[i], sb, ex[i]); end
        end
        @(negedge Clk); DrawX = 10'd100; DrawY = 10'd51; #1;
        n_cmp++; if (rom_addr_b !== 4'd0) begin n_bad++; $display("FAIL scale_addr_y51: got %0d want 0", rom_addr_b); end
        @(negedge Clk); DrawY = 10'd52; #1;
        n_cmp++; if (rom_addr_b !== 4'd1) begin n_bad++; $display("FAIL scale_addr_y52: got %0d want 1", rom_addr_b); end
    endtask

    task automatic test_random(input int n);
        logic ea [$];
        logic eb [$];
        logic wa, wb;
        int   d, x, y, ytop;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge Clk);
            if (i >= 2) begin
                wa = ea.pop_front();
                wb = eb.pop_front();
                n_cmp++; if (is_sprite_a !== wa) begin n_bad++; $display("FAIL random_a mode=%0d it=%0d: got %b want %b", mode, i, is_sprite_a, wa); end
                n_cmp++; if (is_sprite_b !== wb) begin n_bad++; $display("FAIL random_b mode=%0d it=%0d: got %b want %b", mode, i, is_sprite_b, wb); end
            end
            d    = i % 2;
            ytop = p_y0(d) + (mode[1] ? off_m[d] : 0);
            x = p_x0(d) - 3 + int'($urandom_range(0, (W << p_sc(d)) + 5));
            y = ytop - 3 + int'($urandom_range(0, (H << p_sc(d)) + 5));
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            DrawX = 10'(x);
            DrawY = 10'(y);
            ea.push_back(model_px(0, x, y));
            eb.push_back(model_px(1, x, y));
        end
    endtask

    task automatic test_scroll();
        logic sa, sb;
        mode = 2'b10;
        do_restart();
        drive_sample(272, 232, sa, sb);
        n_cmp++; if (sa !== 1'b0) begin n_bad++; $display("FAIL scroll_start_hidden: got %b want 0", sa); end
        for (int t = 1; t <= 123; t++) begin
            frame_tick();
            if (t == 60) test_random(40);
        end
        n_cmp++; if (scroll_done_a !== 1'b0) begin n_bad++; $display("FAIL scroll_done_early: got %b want 0", scroll_done_a); end
        @(negedge Clk); frame_clk = 1'b1;
        @(negedge Clk); frame_clk = 1'b0;
        n_cmp++; if (scroll_done_a !== 1'b0) begin n_bad++; $display("FAIL scroll_done_lag: got %b want 0", scroll_done_a); end
        @(negedge Clk);
        n_cmp++; if (scroll_done_a !== 1'b1) begin n_bad++; $display("FAIL scroll_done_rise: got %b want 1", scroll_done_a); end
        off_m[0] = 0;
        off_m[1] = 0;
        drive_sample(272, 232, sa, sb);
        n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL scroll_landed: got %b want 1", sa); end
        frame_tick();
        n_cmp++; if (scroll_done_a !== 1'b1) begin n_bad++; $display("FAIL scroll_hold_done: got %b want 1", scroll_done_a); end
        drive_sample(272, 232, sa, sb);
        n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL scroll_hold_pos: got %b want 1", sa); end
        test_random(40);
    endtask

    task automatic test_blink();
        logic sa, sb, want;
        mode = 2'b01;
        do_restart();
        for (int n = 0; n < 6; n++) begin
            drive_sample(100, 50, sa, sb);
            want = ((n / 2) % 2) == 0;
            n_cmp++; if (sb !== want) begin n_bad++; $display("FAIL blink_b_tick%0d: got %b want %b", n, sb, want); end
            drive_sample(272, 232, sa, sb);
            n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL blink_a_tick%0d: got %b want 1", n, sa); end
            frame_tick();
        end
        test_random(40);
    endtask

    task automatic test_mode11();
        logic sa, sb, want;
        mode = 2'b11;
        do_restart();
        for (int t = 1; t <= 124; t++) begin
            frame_tick();
            if (t == 10) begin
                drive_sample(272, 232 + 228, sa, sb);
                n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL m11_scrolling_shown: got %b want 1", sa); end
            end
        end
        for (int k = 1; k <= 31; k++) begin
            frame_tick();
            drive_sample(272, 232, sa, sb);
            want = (k < 30);
            n_cmp++; if (sa !== want) begin n_bad++; $display("FAIL m11_blink_k%0d: got %b want %b", k, sa, want); end
        end
        test_random(60);
    endtask

    task automatic test_restart_with_tick();
        logic sa, sb;
        mode = 2'b11;
        @(negedge Clk);
        restart = 1'b1;
        frame_clk = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        frame_clk = 1'b0;
        model_restart();
        @(negedge Clk);
        n_cmp++; if (scroll_done_a !== 1'b0) begin n_bad++; $display("FAIL restart_tick_done: got %b want 0", scroll_done_a); end
        drive_sample(272, 232 + 248, sa, sb);
        n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL restart_tick_offset: got %b want 1", sa); end
        frame_tick();
        drive_sample(272, 232 + 246, sa, sb);
        n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL restart_next_offset: got %b want 1", sa); end
        test_random(30);
    endtask

    task automatic test_reset_mid();
        logic sa, sb;
        mode = 2'b00;
        drive_sample(272, 232, sa, sb);
        n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL rst_mid_before: got %b want 1", sa); end
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        n_cmp++; if (is_sprite_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_async: got %b want 0", is_sprite_a); end
        @(negedge Clk);
        Reset = 1'b1;
        model_restart();
        @(negedge Clk);
        n_cmp++; if (is_sprite_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_latency: got %b want 0", is_sprite_a); end
        n_cmp++; if (scroll_done_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done: got %b want 0", scroll_done_a); end
        @(negedge Clk);
        n_cmp++; if (is_sprite_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_resume: got %b want 1", is_sprite_a); end
        mode = 2'b10;
        drive_sample(272, 232 + 248, sa, sb);
        n_cmp++; if (sa !== 1'b1) begin n_bad++; $display("FAIL rst_mid_offset: got %b want 1", sa); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++)
                rom_m[d][r] = {$urandom(), $urandom(), $urandom()};
        rom_m[0][0] = {1'b1, 94'd0, 1'b1};
        rom_m[1][0][95] = 1'b1;
        rom_m[1][0][94] = 1'b0;
        model_restart();
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        test_reset();
        test_static_bounds();
        test_scale();
        test_random(80);
        test_scroll();
        test_blink();
        test_mode11();
        test_restart_with_tick();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
